red_pitaya_bus_master: RTL



---
 rtl/red_pitaya_bus_pkg.sv | 19 +
 rtl/red_pitaya_bus_master.sv | 114 +++++++++++
 2 files changed

// File: rtl/red_pitaya_bus_pkg.sv
// rtl/red_pitaya_bus_pkg.sv - shared types and constants for sys-bus bridges
package red_pitaya_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } bus_state_e;

  localparam int BUS_AW = 32;
  localparam int BUS_DW = 32;

  // Response-code bit positions, shared by every bridge that reports bus outcomes
  localparam int RSP_CODE_W   = 2;
  localparam int RSP_ERR_BIT  = 0;
  localparam int RSP_TOUT_BIT = 1;

endpackage

// File: rtl/red_pitaya_bus_master.sv
// rtl/red_pitaya_bus_master.sv - single-transaction sys-bus initiator with timeout
module red_pitaya_bus_master
  import red_pitaya_bus_pkg::*;
#(
  parameter int AW      = BUS_AW,
  parameter int DW      = BUS_DW,
  parameter int TIMEOUT = 255
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic            cmd_we_i,
  input  logic [AW-1:0]   cmd_addr_i,
  input  logic [DW-1:0]   cmd_wdata_i,
  input  logic [DW/8-1:0] cmd_sel_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [DW-1:0]   rsp_rdata_o,
  output logic            rsp_err_o,
  output logic            rsp_tout_o,
  output logic            busy_o,
  output logic [AW-1:0]   sys_addr_o,
  output logic [DW-1:0]   sys_wdata_o,
  output logic [DW/8-1:0] sys_sel_o,
  output logic            sys_wen_o,
  output logic            sys_ren_o,
  input  logic [DW-1:0]   sys_rdata_i,
  input  logic            sys_err_i,
  input  logic            sys_ack_i
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TOUT_LAST = CW'(TIMEOUT - 1);

  bus_state_e state, state_next;
  logic [CW-1:0] cnt;
  logic we_q;
  logic accept, hit, expire;
  logic [RSP_CODE_W-1:0] rsp_code;

  assign accept = cmd_valid_i & cmd_ready_o;
  assign hit    = sys_ack_i | sys_err_i;
  assign expire = (cnt == TOUT_LAST);

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept) state_next = ST_REQ;
      ST_REQ:  state_next = ST_WAIT;
      ST_WAIT: if (hit || expire) state_next = ST_RESP;
      ST_RESP: if (rsp_ready_i) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Timeout is reported only when no ack/err arrived in the final WAIT cycle
  always_comb begin
    rsp_code = '0;
    rsp_code[RSP_ERR_BIT]  = sys_err_i;
    rsp_code[RSP_TOUT_BIT] = ~hit;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cmd_ready_o <= 1'b1;
      busy_o      <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
      rsp_tout_o  <= 1'b0;
      sys_addr_o  <= '0;
      sys_wdata_o <= '0;
      sys_sel_o   <= '0;
      sys_wen_o   <= 1'b0;
      sys_ren_o   <= 1'b0;
      we_q        <= 1'b0;
      cnt         <= '0;
    end else begin
      cmd_ready_o <= (state_next == ST_IDLE);
      busy_o      <= (state_next != ST_IDLE);
      rsp_valid_o <= (state_next == ST_RESP);
      sys_wen_o   <= 1'b0;
      sys_ren_o   <= 1'b0;

      if (state == ST_IDLE && accept) begin
        sys_addr_o  <= cmd_addr_i;
        sys_wdata_o <= cmd_wdata_i;
        sys_sel_o   <= cmd_sel_i;
        sys_wen_o   <= cmd_we_i;
        sys_ren_o   <= ~cmd_we_i;
        we_q        <= cmd_we_i;
      end

      if (state == ST_REQ) cnt <= '0;

      if (state == ST_WAIT) begin
        if (hit || expire) begin
          rsp_err_o   <= rsp_code[RSP_ERR_BIT];
          rsp_tout_o  <= rsp_code[RSP_TOUT_BIT];
          rsp_rdata_o <= (hit && !sys_err_i && !we_q) ? sys_rdata_i : '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule
